// File: rtl/mult_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: FSM encoding and partial-product selects.
package mult_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [2:0] PP_ZERO = 3'd0;
    localparam logic [2:0] PP_POS1 = 3'd1;
    localparam logic [2:0] PP_POS2 = 3'd2;
    localparam logic [2:0] PP_NEG1 = 3'd3;
    localparam logic [2:0] PP_NEG2 = 3'd4;

    // Map a Booth digit {q[i+1], q[i], q[i-1]} onto its partial-product multiple.
    function automatic logic [2:0] booth_sel(input logic [2:0] digit);
        logic [2:0] sel;
        sel = PP_ZERO;
        case (digit)
            3'b001, 3'b010: sel = PP_POS1;
            3'b011:         sel = PP_POS2;
            3'b100:         sel = PP_NEG2;
            3'b101, 3'b110: sel = PP_NEG1;
            default:        sel = PP_ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Combinational radix-4 Booth encoder: digit x multiplicand -> sign-correct partial product.
module booth_r4_encoder
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]       digit,
    input  logic [WIDTH+1:0] mcand,
    output logic [WIDTH+2:0] pp_c
);

    logic [WIDTH+2:0] m1;
    logic [WIDTH+2:0] m2;

    assign m1 = {mcand[WIDTH+1], mcand};
    assign m2 = {mcand, 1'b0};

    always_comb begin
        pp_c = '0;
        case (booth_sel(digit))
            PP_POS1: pp_c = m1;
            PP_POS2: pp_c = m2;
            PP_NEG1: pp_c = (WIDTH+3)'(-m1);
            PP_NEG2: pp_c = (WIDTH+3)'(-m2);
            default: pp_c = '0;
        endcase
    end

endmodule

// File: rtl/booth_r4_multiplier.sv
// Multi-cycle radix-4 Booth multiplier retiring two multiplier bits per cycle,
// with op_start/op_clear/op_done handshake and a busy flag.
module booth_r4_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 signed_mode,
    input  logic                 op_start,
    input  logic                 op_clear,
    output logic [2*WIDTH-1:0]   result,
    output logic                 op_done,
    output logic                 busy
);

    localparam int unsigned EXT_W = WIDTH + 2;
    localparam int unsigned ACC_W = WIDTH + 3;
    localparam int unsigned N_CYC = WIDTH / 2 + 1;
    localparam int unsigned CNT_W = $clog2(N_CYC + 1);

    logic [1:0]           state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [EXT_W-1:0]     q_q, q_d;
    logic                 qm1_q, qm1_d;
    logic [EXT_W-1:0]     mcand_q, mcand_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   result_d;
    logic                 done_d;
    logic                 busy_d;

    logic [EXT_W-1:0]     ext_a_c;
    logic [EXT_W-1:0]     ext_b_c;
    logic [ACC_W-1:0]     pp_c;
    logic [ACC_W-1:0]     sum_c;
    logic [ACC_W-1:0]     acc_sh_c;
    logic [EXT_W-1:0]     q_sh_c;

    assign ext_a_c = signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand} : {2'b00, multiplicand};
    assign ext_b_c = signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier} : {2'b00, multiplier};

    booth_r4_encoder #(.WIDTH(WIDTH)) u_encoder (
        .digit (({q_q[1], q_q[0], qm1_q})),
        .mcand (mcand_q),
        .pp_c  (pp_c)
    );

    // One Booth step: accumulate, then arithmetic-shift {acc, q} right by two.
    assign sum_c    = acc_q + pp_c;
    assign acc_sh_c = {{2{sum_c[ACC_W-1]}}, sum_c[ACC_W-1:2]};
    assign q_sh_c   = {sum_c[1:0], q_q[EXT_W-1:2]};

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        q_d      = q_q;
        qm1_d    = qm1_q;
        mcand_d  = mcand_q;
        cnt_d    = cnt_q;
        result_d = result;
        done_d   = op_done;
        busy_d   = busy;

        case (state_q)
            ST_IDLE: begin
                result_d = '0;
                done_d   = 1'b0;
                busy_d   = 1'b0;
                if (op_start) begin
                    mcand_d = ext_a_c;
                    q_d     = ext_b_c;
                    qm1_d   = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                acc_d = acc_sh_c;
                q_d   = q_sh_c;
                qm1_d = q_q[1];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N_CYC - 1)) begin
                    // Low 2*WIDTH bits of the full (WIDTH+2)x(WIDTH+2) product.
                    result_d = {acc_sh_c[WIDTH-3:0], q_sh_c};
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d  = ST_IDLE;
                result_d = '0;
                done_d   = 1'b0;
                busy_d   = 1'b0;
                cnt_d    = '0;
            end
        endcase

        if (op_clear) begin
            state_d  = ST_IDLE;
            result_d = '0;
            done_d   = 1'b0;
            busy_d   = 1'b0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            mcand_q <= '0;
            cnt_q   <= '0;
            result  <= '0;
            op_done <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            result  <= result_d;
            op_done <= done_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_booth_r4_multiplier.sv
// Self-checking bench for booth_r4_multiplier at WIDTH=32 and WIDTH=8 against an arithmetic model.
module tb_booth_r4_multiplier;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] mcand, mplier;
    logic        smode, op_start, op_clear;
    logic [63:0] result;
    logic        op_done, busy;

    logic [7:0]  mcand8, mplier8;
    logic        smode8, op_start8, op_clear8;
    logic [15:0] result8;
    logic        op_done8, busy8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    booth_r4_multiplier #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .multiplicand(mcand), .multiplier(mplier),
        .signed_mode(smode), .op_start(op_start), .op_clear(op_clear),
        .result(result), .op_done(op_done), .busy(busy)
    );

    booth_r4_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .multiplicand(mcand8), .multiplier(mplier8),
        .signed_mode(smode8), .op_start(op_start8), .op_clear(op_clear8),
        .result(result8), .op_done(op_done8), .busy(busy8)
    );

    // Reference: product of the extended operands, truncated to 2*WIDTH bits.
    function automatic logic [63:0] model32(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa, sb;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic signed [15:0] sa, sb;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            return 16'(sa * sb);
        end
        return {8'd0, a} * {8'd0, b};
    endfunction

    // Launch one 32-bit operation; scramble inputs during EXEC and report result, latency, EXEC sanity.
    task automatic run_op32(input logic [31:0] a, input logic [31:0] b, input logic s, input bit hold,
                            output logic [63:0] res, output int lat, output bit exec_ok);
        @(negedge clk);
        mcand = a; mplier = b; smode = s; op_start = 1'b1;
        @(posedge clk); #1;
        exec_ok = (busy === 1'b1) && (op_done === 1'b0) && (result === 64'd0);
        @(negedge clk);
        op_start = hold;
        mcand = $urandom; mplier = $urandom; smode = ~s;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (op_done === 1'b1) break;
            if (busy !== 1'b1 || result !== 64'd0) exec_ok = 1'b0;
        end
        res = result;
    endtask

    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                           output logic [15:0] res, output int lat);
        @(negedge clk);
        mcand8 = a; mplier8 = b; smode8 = s; op_start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_start8 = 1'b0;
        mcand8 = 8'($urandom); mplier8 = 8'($urandom); smode8 = ~s;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (op_done8 === 1'b1) break;
        end
        res = result8;
    endtask

    task automatic clear32();
        @(negedge clk); op_clear = 1'b1; op_start = 1'b0;
        @(posedge clk);
        @(negedge clk); op_clear = 1'b0;
    endtask

    task automatic clear8();
        @(negedge clk); op_clear8 = 1'b1; op_start8 = 1'b0;
        @(posedge clk);
        @(negedge clk); op_clear8 = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        op_start = 1'b0; op_clear = 1'b0; mcand = '0; mplier = '0; smode = 1'b0;
        op_start8 = 1'b0; op_clear8 = 1'b0; mcand8 = '0; mplier8 = '0; smode8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({result, op_done, busy} !== 66'd0) begin
            bad++; $display("FAIL reset32: got res=%h done=%b busy=%b expected all 0", result, op_done, busy);
        end
        total++;
        if ({result8, op_done8, busy8} !== 18'd0) begin
            bad++; $display("FAIL reset8: got res=%h done=%b busy=%b expected all 0", result8, op_done8, busy8);
        end
        @(negedge clk); reset_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] a [6] = '{32'd7, 32'd37, 32'd37, 32'hFFFFFFFF, 32'h80000000, 32'd0};
        logic [31:0] b [6] = '{32'd50, 32'hFFFFFFF2, 32'hFFFFFFF2, 32'hFFFFFFFF, 32'h80000000, 32'h12345678};
        logic        s [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [63:0] e [6] = '{64'd350, 64'hFFFFFFFFFFFFFDFA, 64'h00000024FFFFFDFA,
                               64'hFFFFFFFE00000001, 64'h4000000000000000, 64'd0};
        logic [63:0] res;
        int lat;
        bit ok;
        for (int i = 0; i < 6; i++) begin
            run_op32(a[i], b[i], s[i], 1'b0, res, lat, ok);
            total++;
            if (res !== e[i]) begin
                bad++; $display("FAIL directed%0d result: got %h expected %h", i, res, e[i]);
            end
            total++;
            if (lat !== 17) begin
                bad++; $display("FAIL directed%0d latency: got %0d expected 17", i, lat);
            end
            total++;
            if (!ok) begin
                bad++; $display("FAIL directed%0d exec: busy/result wrong during EXEC, got ok=%0b expected 1", i, ok);
            end
            clear32();
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic s;
        logic [63:0] res, exp;
        int lat;
        bit ok;
        for (int i = 0; i < 30; i++) begin
            a = $urandom; b = $urandom; s = 1'($urandom);
            if (i % 5 == 0) a = {1'b1, 31'($urandom_range(0, 3))};
            exp = model32(a, b, s);
            run_op32(a, b, s, 1'b0, res, lat, ok);
            total++;
            if (res !== exp || lat !== 17 || !ok) begin
                bad++;
                $display("FAIL random%0d: a=%h b=%h s=%b got %h lat=%0d ok=%0b expected %h lat=17 ok=1",
                         i, a, b, s, res, lat, ok, exp);
            end
            clear32();
        end
    endtask

    task automatic test_hold_start();
        logic [63:0] res;
        int lat;
        bit ok;
        run_op32(32'd11, 32'd5, 1'b0, 1'b1, res, lat, ok);
        total++;
        if (res !== 64'd55) begin
            bad++; $display("FAIL hold result: got %h expected %h", res, 64'd55);
        end
        repeat (6) @(posedge clk);
        #1;
        total++;
        if (result !== 64'd55 || op_done !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL hold done: got res=%h done=%b busy=%b expected 37 1 0", result, op_done, busy);
        end
        @(negedge clk); op_clear = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({result, op_done, busy} !== 66'd0) begin
            bad++; $display("FAIL clear_and_start: got res=%h done=%b busy=%b expected all 0", result, op_done, busy);
        end
        @(negedge clk); op_clear = 1'b0; op_start = 1'b0;
        run_op32(32'd11, 32'd12, 1'b0, 1'b0, res, lat, ok);
        total++;
        if (res !== 64'd132) begin
            bad++; $display("FAIL after_hold result: got %h expected %h", res, 64'd132);
        end
        clear32();
    endtask

    task automatic test_clear_mid();
        logic [63:0] res;
        int lat;
        bit ok;
        @(negedge clk); mcand = 32'd99; mplier = 32'd77; smode = 1'b0; op_start = 1'b1;
        @(posedge clk);
        @(negedge clk); op_start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); op_clear = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({result, op_done, busy} !== 66'd0) begin
            bad++; $display("FAIL clear_mid: got res=%h done=%b busy=%b expected all 0", result, op_done, busy);
        end
        @(negedge clk); op_clear = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (op_done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL clear_mid idle: got done=%b busy=%b expected 0 0", op_done, busy);
        end
        run_op32(32'd13, 32'd14, 1'b0, 1'b0, res, lat, ok);
        total++;
        if (res !== 64'd182 || lat !== 17) begin
            bad++; $display("FAIL after_clear: got %h lat=%0d expected %h lat=17", res, lat, 64'd182);
        end
        clear32();
    endtask

    task automatic test_reset_mid();
        logic [63:0] res;
        int lat;
        bit ok;
        @(negedge clk); mcand = 32'd1234; mplier = 32'd5678; smode = 1'b0; op_start = 1'b1;
        @(posedge clk);
        @(negedge clk); op_start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk); reset_n = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({result, op_done, busy} !== 66'd0) begin
            bad++; $display("FAIL reset_mid: got res=%h done=%b busy=%b expected all 0", result, op_done, busy);
        end
        @(negedge clk); reset_n = 1'b1;
        run_op32(32'd7, 32'd50, 1'b0, 1'b0, res, lat, ok);
        total++;
        if (res !== 64'd350 || lat !== 17) begin
            bad++; $display("FAIL after_reset: got %h lat=%0d expected %h lat=17", res, lat, 64'd350);
        end
        clear32();
    endtask

    task automatic test_width8();
        logic [7:0]  a [5] = '{8'd7, 8'd37, 8'd37, 8'hFF, 8'h80};
        logic [7:0]  b [5] = '{8'd50, 8'hF2, 8'hF2, 8'hFF, 8'h80};
        logic        s [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [15:0] e [5] = '{16'd350, 16'hFDFA, 16'h22FA, 16'hFE01, 16'h4000};
        logic [7:0]  ra, rb;
        logic        rs;
        logic [15:0] res, exp;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op8(a[i], b[i], s[i], res, lat);
            total++;
            if (res !== e[i] || lat !== 5) begin
                bad++; $display("FAIL w8 directed%0d: got %h lat=%0d expected %h lat=5", i, res, lat, e[i]);
            end
            clear8();
        end
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            exp = model8(ra, rb, rs);
            run_op8(ra, rb, rs, res, lat);
            total++;
            if (res !== exp || lat !== 5) begin
                bad++; $display("FAIL w8 random%0d: a=%h b=%h s=%b got %h lat=%0d expected %h lat=5",
                                i, ra, rb, rs, res, lat, exp);
            end
            clear8();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold_start();
        test_clear_mid();
        test_reset_mid();
        test_width8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
